// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and serialises them
// with a 16x oversampled baud tick, optional parity and configurable stop length.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     dvsr,
  input  logic            parity_en,
  input  logic            parity_odd,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [10:0]     cnt, cnt_next, dvsr_l;
  logic [5:0]      s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] sreg, sreg_next;
  logic            tx_reg, tx_next;
  logic            pen_l, par_bit;
  logic            tick;

  assign tick = (cnt == dvsr_l);
  assign tx   = tx_reg;
  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dvsr_l  <= '0;
      s       <= '0;
      n       <= '0;
      sreg    <= '0;
      tx_reg  <= 1'b1;
      pen_l   <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      s      <= s_next;
      n      <= n_next;
      sreg   <= sreg_next;
      tx_reg <= tx_next;
      // Frame configuration is frozen at the pop so mid-frame input changes are ignored.
      if (rd) begin
        dvsr_l  <= dvsr;
        pen_l   <= parity_en;
        par_bit <= (^r_data) ^ parity_odd;
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = (state == IDLE) ? 11'd0 : (tick ? 11'd0 : cnt + 11'd1);
    s_next       = s;
    n_next       = n;
    sreg_next    = sreg;
    tx_next      = tx_reg;
    rd           = 1'b0;
    tx_done_tick = 1'b0;

    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty && !reset) begin
          rd         = 1'b1;
          state_next = START;
          sreg_next  = r_data;
          s_next     = '0;
          n_next     = '0;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (s == 6'd15) begin
            s_next     = '0;
            state_next = DATA;
            tx_next    = sreg[0];
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == 6'd15) begin
            s_next    = '0;
            sreg_next = sreg >> 1;
            if (n == 3'(DBIT-1)) begin
              state_next = pen_l ? PARITY : STOP;
              tx_next    = pen_l ? par_bit : 1'b1;
            end else begin
              n_next  = n + 3'd1;
              tx_next = sreg[1];
            end
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s == 6'd15) begin
            s_next     = '0;
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == 6'(SB_TICK-1)) begin
            s_next       = '0;
            state_next   = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: an upstream FIFO model feeds words,
// a scoreboard holds expected frames, and each frame is checked bit by bit.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr = '0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        empty;
  logic [7:0]  r_data;
  logic        rd, tx, busy, tx_done_tick;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .empty        (empty),
    .r_data       (r_data),
    .rd           (rd),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: the bench writes, the DUT pops via rd.
  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_count = 0;

  assign empty  = (wr_ptr == rd_ptr);
  assign r_data = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (rd && !empty) rd_ptr <= rd_ptr + 1;
    if (rd) rd_count <= rd_count + 1;
  end

  typedef struct {
    logic [7:0] data;
    int         d;
    bit         pen;
    bit         podd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] data, input int d, input bit pen, input bit podd);
    exp_t e;
    mem[wr_ptr[3:0]] = data;
    wr_ptr = wr_ptr + 1;
    e.data = data; e.d = d; e.pen = pen; e.podd = podd;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the rd cycle, sampling on falling edges.
  task automatic wait_rd(input string tag, output int gap);
    gap = 0;
    while (1) begin
      @(negedge clk);
      gap++;
      if (rd || gap >= 3000) break;
    end
    check({tag, "_rd_seen"}, rd, 1);
  endtask

  task automatic check_frame(input string tag, output int gap);
    exp_t        e;
    int          p, nbits, len_exp, done_at, c0;
    logic [11:0] bits;
    wait_rd(tag, gap);
    if (!rd) return;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    c0 = rd_count;
    check({tag, "_idle_high"}, tx, 1);
    p       = 16 * (e.d + 1);
    nbits   = e.pen ? 11 : 10;
    len_exp = nbits * p;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = e.data;
    if (e.pen) bits[9] = (^e.data) ^ e.podd;
    done_at = 0;
    for (int j = 1; j < len_exp + 20; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check({tag, "_start_edge"}, tx, 0);
        check({tag, "_busy"}, busy, 1);
      end
      if (((j - 1) % p) == p / 2 && ((j - 1) / p) < nbits)
        check({tag, "_bit"}, tx, bits[(j - 1) / p]);
      if (tx_done_tick) begin
        done_at = j;
        break;
      end
    end
    check({tag, "_len"}, done_at, len_exp);
    check({tag, "_one_pop"}, rd_count - c0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  rd_seen, tx_low, busy_seen;
    int  c0;

    // Reset holds outputs quiet even with a word waiting.
    repeat (3) @(negedge clk);
    load_word(8'hA5, 0, 0, 0);
    #1;
    check("rst_rd", rd, 0);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done_tick, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 0xA5, dvsr=0, no parity: 160-cycle frame.
    check_frame("a5_d0", g);
    check("a5_d0_gap", g, 1);

    // Parity even then odd at dvsr=3.
    dvsr = 11'd3; parity_en = 1'b1; parity_odd = 1'b0;
    @(posedge clk); #1 load_word(8'hA5, 3, 1, 0);
    check_frame("par_even", g);
    parity_odd = 1'b1;
    @(posedge clk); #1 load_word(8'hA5, 3, 1, 1);
    check_frame("par_odd", g);

    // Three back-to-back words.
    dvsr = 11'd0; parity_en = 1'b0; parity_odd = 1'b0;
    @(posedge clk); #1;
    load_word(8'h01, 0, 0, 0);
    load_word(8'h02, 0, 0, 0);
    load_word(8'h03, 0, 0, 0);
    check_frame("b2b0", g);
    check_frame("b2b1", g);
    check("b2b1_gap", g, 1);
    check_frame("b2b2", g);
    check("b2b2_gap", g, 1);

    // dvsr changes mid-frame: only the next frame sees it.
    @(posedge clk); #1;
    load_word(8'h55, 0, 0, 0);
    load_word(8'h96, 9, 0, 0);
    fork
      check_frame("dv0", g);
      begin
        repeat (40) @(negedge clk);
        dvsr = 11'd9;
      end
    join
    check_frame("dv9", g);
    check("dv9_gap", g, 1);
    dvsr = 11'd0;

    // Reset during data bit 3 aborts the frame without popping.
    @(posedge clk); #1 load_word(8'h3C, 0, 0, 0);
    wait_rd("abort", g);
    void'(sb.pop_front());
    c0 = rd_count;
    repeat (70) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    load_word(8'hC3, 0, 0, 0);
    #1;
    check("abort_rd", rd, 0);
    repeat (5) @(negedge clk);
    check("abort_no_pop", rd_count - c0, 1);
    check("abort_fifo_level", wr_ptr - rd_ptr, 1);
    @(posedge clk); #1 reset = 1'b0;
    check_frame("post_rst", g);
    check("post_rst_gap", g, 1);

    // Empty FIFO for 1000 cycles: nothing happens.
    rd_seen = 0; tx_low = 0; busy_seen = 0;
    c0 = rd_count;
    repeat (1000) begin
      @(negedge clk);
      if (rd) rd_seen = 1;
      if (!tx) tx_low = 1;
      if (busy) busy_seen = 1;
    end
    check("empty_rd", rd_seen, 0);
    check("empty_tx", tx_low, 0);
    check("empty_busy", busy_seen, 0);
    check("empty_pops", rd_count - c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DBIT, default 8, meaning number of data bits per frame (5 to 8).
REQ-002 Parameter SB_TICK, default 16, meaning stop-bit length in oversample ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits).
REQ-003 Port clk  input  1  system clock, all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port dvsr  input  11  baud divisor; oversample tick period = dvsr+1 clk cycles.
REQ-006 Port parity_en  input  1  1 = append parity bit after data bits.
REQ-007 Port parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
REQ-008 Port empty  input  1  upstream FIFO empty flag.
REQ-009 Port r_data  input  DBIT  upstream FIFO head word, valid whenever empty=0.
REQ-010 Port rd  output  1  one-cycle pop strobe to upstream FIFO.
REQ-011 Port tx  output  1  serial line, idle high, registered.
REQ-012 Port busy  output  1  high from the cycle after rd until return to IDLE.
REQ-013 Port tx_done_tick  output  1  one-cycle pulse on completion of the stop bit.

Function
REQ-014 The block SHALL contain the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-015 The block SHALL assert rd combinationally for exactly one cycle when state=IDLE and empty=0, and never in any other state.
REQ-016 On that rising edge the block SHALL capture r_data into the shift register, capture dvsr, parity_en and parity_odd for the whole frame, clear the tick and bit counters, and enter START.
REQ-017 The tick counter SHALL count 0..dvsr_latched and issue a tick on the cycle count==dvsr_latched, then wrap to 0; dvsr=0 SHALL give a tick every cycle.
REQ-018 START SHALL drive tx=0 for 16 ticks, then enter DATA.
REQ-019 DATA SHALL send DBIT bits LSB first, 16 ticks per bit, shifting right after each bit.
REQ-020 After the last data bit, DATA SHALL enter PARITY if parity_en_latched=1, else STOP.
REQ-021 PARITY SHALL drive XOR of the data bits (inverted when parity_odd_latched=1) for 16 ticks, then enter STOP.
REQ-022 STOP SHALL drive tx=1 for SB_TICK ticks, pulse tx_done_tick for one cycle on the final tick, and return to IDLE.
REQ-023 The frame length SHALL be (16*(1+DBIT+parity_en)+SB_TICK)*(dvsr+1) cycles, measured from the rd cycle to the tx_done_tick cycle inclusive of rd.
REQ-024 Back-to-back operation: if empty=0 in the first IDLE cycle after STOP, rd SHALL assert in that cycle, giving exactly one idle-high cycle between frames.
REQ-025 tx SHALL be driven from a register so that it has no combinational glitches; tx SHALL be 1 in IDLE.
REQ-026 Changes to dvsr or the parity inputs mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-027 While reset=1 the block SHALL hold state=IDLE, tx=1, rd=0, busy=0, tx_done_tick=0, and all counters and shift registers at 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with tx=1 asynchronously, and SHALL NOT pop the FIFO.
REQ-029 After reset deasserts, the block SHALL start a frame only on a fresh IDLE cycle with empty=0.

Verification
REQ-030 Scenario: dvsr=0, parity off, SB_TICK=16, r_data=0xA5, empty=0 for one word. Required: rd for 1 cycle; tx low 16 cycles; bits 1,0,1,0,0,1,0,1 for 16 cycles each; high 16 cycles; tx_done_tick 160 cycles after rd.
REQ-031 Scenario: dvsr=3, parity_en=1, parity_odd=0, data 0xA5. Required: parity bit 0; frame length 176*4=704 cycles. Repeat with parity_odd=1: parity bit 1.
REQ-032 Scenario: FIFO holds three words 0x01, 0x02, 0x03 and dvsr=0. Required: three rd pulses spaced 161 cycles apart, frames in order, one idle-high cycle between frames.
REQ-033 Scenario: change dvsr from 0 to 9 during DATA. Required: current frame keeps 1-cycle ticks; the next frame uses 10-cycle ticks.
REQ-034 Scenario: reset pulse during bit 3 of DATA. Required: tx=1 and busy=0 immediately; no extra rd; the next frame starts cleanly with a full start bit.
REQ-035 Scenario: empty held at 1 for 1000 cycles. Required: rd never asserts, tx stays 1, busy stays 0.
